dvp_frame_tx: RTL

- Transmitter for the OV7670-style DVP camera bus.
- Generates VSYNC/HREF timing and RGB565 byte pairs on an 8-bit bus, sourced from a 12-bit frame-buffer read port or an internal test pattern.
- Drives the capture path in loopback and in simulation without a physical sensor.
- The receiver samples on the falling edge of `pclk`; this block updates all bus outputs on the rising edge.

---
 rtl/dvp_frame_tx_if.sv | 22 ++
 rtl/dvp_frame_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dvp_frame_tx_if.sv
// DVP transmitter bus: frame-buffer read port, control inputs and camera-side outputs.
// master = transmitter side, slave = frame buffer / capture side.
interface dvp_frame_tx_if;
  logic        enable;
  logic [1:0]  pat_sel;
  logic [16:0] rd_addr;
  logic [11:0] rd_data;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        frame_done;

  modport master (
    input  enable, pat_sel, rd_data,
    output rd_addr, vsync, href, d, frame_done
  );

  modport slave (
    output enable, pat_sel, rd_data,
    input  rd_addr, vsync, href, d, frame_done
  );
endinterface

// File: rtl/dvp_frame_tx.sv
// OV7670-style DVP transmitter: VSYNC/HREF timing and RGB565 bytes from RAM or test patterns.
// All outputs registered on the rising pclk edge; no backpressure, the frame runs free once started.
module dvp_frame_tx #(
  parameter int H_ACTIVE  = 320,
  parameter int H_BLANK   = 144,
  parameter int V_ACTIVE  = 240,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic           pclk,
  input  logic           reset,
  dvp_frame_tx_if.master bus
);
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int L    = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(L);
  localparam int VMAX = max2(max2(VS_LINES, VBP_LINES), max2(V_ACTIVE, VFP_LINES));
  localparam int VW   = $clog2(VMAX + 1);
  localparam logic [16:0] LAST_ADDR = 17'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [16:0]   rd_addr_q, rd_addr_d;
  logic [1:0]    pat_q, pat_d;
  logic [11:0]   pix_q, pix_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    d_q, d_d;
  logic          frame_done_q, frame_done_d;

  logic          line_end, last_line, pix_slot;
  logic [VW-1:0] lines_m1;
  logic [HW-1:0] col;
  logic [2:0]    bar;
  logic [11:0]   bar_word, src_word, word;
  logic [4:0]    r5, b5;
  logic [5:0]    g6;

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    rd_addr_d = rd_addr_q;
    pat_d     = pat_q;

    line_end = (hcnt_q == HW'(L - 1));
    case (state_q)
      S_VSYNC:  lines_m1 = VW'(VS_LINES - 1);
      S_VBP:    lines_m1 = VW'(VBP_LINES - 1);
      S_ACTIVE: lines_m1 = VW'(V_ACTIVE - 1);
      default:  lines_m1 = VW'(VFP_LINES - 1);
    endcase
    last_line = (vcnt_q == lines_m1);

    if (state_q == S_IDLE) begin
      hcnt_d = '0;
      vcnt_d = '0;
      if (bus.enable) state_d = S_VSYNC;
    end else begin
      hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
      if (line_end) begin
        if (last_line) begin
          vcnt_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBP;
            S_VBP:    state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFP;
            default:  state_d = bus.enable ? S_VSYNC : S_IDLE;
          endcase
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end
    end

    if (state_d == S_VSYNC && state_q != S_VSYNC) begin
      rd_addr_d = '0;
      pat_d     = bus.pat_sel;
    end

    href_d   = (state_d == S_ACTIVE) && (hcnt_d < HW'(2 * H_ACTIVE));
    // A high-byte slot fetches a fresh word; the address moves on so the next
    // pixel's data is back from the RAM two cycles later.
    pix_slot = href_d && !hcnt_d[0];
    if (pix_slot && rd_addr_q != LAST_ADDR) rd_addr_d = rd_addr_q + 1'b1;

    col = hcnt_d >> 1;
    bar = 3'((32'(col) * 8) / H_ACTIVE);
    case (bar)
      3'd0:    bar_word = 12'hFFF;
      3'd1:    bar_word = 12'hFF0;
      3'd2:    bar_word = 12'h0FF;
      3'd3:    bar_word = 12'h0F0;
      3'd4:    bar_word = 12'hF0F;
      3'd5:    bar_word = 12'hF00;
      3'd6:    bar_word = 12'h00F;
      default: bar_word = 12'h000;
    endcase
    case (pat_q)
      2'd0:    src_word = bus.rd_data;
      2'd1:    src_word = bar_word;
      2'd2:    src_word = 12'(col);
      default: src_word = 12'hFFF;
    endcase

    word  = pix_slot ? src_word : pix_q;
    pix_d = word;
    r5    = {word[11:8], word[11]};
    g6    = {word[7:4], word[7:6]};
    b5    = {word[3:0], word[3]};

    if (!href_d)       d_d = 8'h00;
    else if (hcnt_d[0]) d_d = {g6[2:0], b5};
    else               d_d = {r5, g6[5:3]};

    vsync_d      = (state_d == S_VSYNC);
    frame_done_d = (state_d == S_VFP) && (hcnt_d == HW'(L - 1)) &&
                   (vcnt_d == VW'(VFP_LINES - 1));
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      rd_addr_q    <= '0;
      pat_q        <= '0;
      pix_q        <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      rd_addr_q    <= rd_addr_d;
      pat_q        <= pat_d;
      pix_q        <= pix_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      d_q          <= d_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.rd_addr    = rd_addr_q;
  assign bus.vsync      = vsync_q;
  assign bus.href       = href_q;
  assign bus.d          = d_q;
  assign bus.frame_done = frame_done_q;
endmodule
